// File: rtl/data_memory_master.sv
// CPU-side load/store master for a 32-bit word-addressed data memory bus.
// Define DATA_MEMORY_MASTER_MISALIGNED_EN to split misaligned accesses over two bus words.
`timescale 1ns/1ps
module data_memory_master (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wrData,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdData,
    output logic        o_rsp_error,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_wrEnable,
    output logic [3:0]  o_bus_wrMask,
    output logic [31:0] o_bus_wrData,
    input  logic [31:0] i_bus_rdData,
    output logic [1:0]  dbg_state
);

`ifdef DATA_MEMORY_MASTER_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // Request handshake: a request transfers when i_req_valid and o_req_ready are both
    // high at a rising edge; the response is a single-cycle pulse with no backpressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state, next_state;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [31:0] rd_lo, rd_hi;

    logic [1:0]  off;
    logic        illegal, misaligned, split, err;
    logic [3:0]  base_mask;
    logic [7:0]  wide_mask;
    logic [63:0] wide_data;
    logic [31:0] assembled, extended;

    assign dbg_state = state;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            req_write    <= 1'b0;
            req_addr     <= 32'd0;
            req_size     <= 2'd0;
            req_unsigned <= 1'b0;
            req_wdata    <= 32'd0;
            rd_lo        <= 32'd0;
            rd_hi        <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && i_req_valid) begin
                req_write    <= i_req_write;
                req_addr     <= i_req_addr;
                req_size     <= i_req_size;
                req_unsigned <= i_req_unsigned;
                req_wdata    <= i_req_wrData;
            end
            if (state == ACC1) rd_lo <= i_bus_rdData;
            if (state == ACC2) rd_hi <= i_bus_rdData;
        end
    end

    // Lane steering: shifting into a double-width vector makes the upper half the second word.
    always_comb begin
        off        = req_addr[1:0];
        illegal    = (req_size == 2'd3);
        misaligned = (req_size == 2'd1 && off == 2'd3) || (req_size == 2'd2 && off != 2'd0);
        split      = misaligned && SPLIT_EN;
        err        = illegal || (misaligned && !SPLIT_EN);
        case (req_size)
            2'd0:    base_mask = 4'b0001;
            2'd1:    base_mask = 4'b0011;
            2'd2:    base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        wide_mask = {4'b0000, base_mask} << off;
        wide_data = {32'd0, req_wdata} << {off, 3'b000};
        assembled = 32'({rd_hi, rd_lo} >> {off, 3'b000});
        case (req_size)
            2'd0:    extended = req_unsigned ? {24'd0, assembled[7:0]}
                                             : {{24{assembled[7]}}, assembled[7:0]};
            2'd1:    extended = req_unsigned ? {16'd0, assembled[15:0]}
                                             : {{16{assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    always_comb begin
        next_state     = state;
        o_req_ready    = 1'b0;
        o_bus_addr     = 32'd0;
        o_bus_wrEnable = 1'b0;
        o_bus_wrMask   = 4'd0;
        o_bus_wrData   = 32'd0;
        o_rsp_valid    = 1'b0;
        o_rsp_rdData   = 32'd0;
        o_rsp_error    = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) next_state = ACC1;
            end
            ACC1: begin
                o_bus_addr = {req_addr[31:2], 2'b00};
                if (req_write && !err) begin
                    o_bus_wrEnable = 1'b1;
                    o_bus_wrMask   = wide_mask[3:0];
                    o_bus_wrData   = wide_data[31:0];
                end
                next_state = split ? ACC2 : RESP;
            end
            ACC2: begin
                o_bus_addr = {req_addr[31:2], 2'b00} + 32'd4;
                if (req_write) begin
                    o_bus_wrEnable = 1'b1;
                    o_bus_wrMask   = wide_mask[7:4];
                    o_bus_wrData   = wide_data[63:32];
                end
                next_state = RESP;
            end
            RESP: begin
                o_rsp_valid  = 1'b1;
                o_rsp_error  = err;
                o_rsp_rdData = (req_write || err) ? 32'd0 : extended;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_memory_master.sv
// Randomized bench for data_memory_master: byte-level reference memory model,
// per-cycle expected queue and a single compare process.
`timescale 1ns/1ps
module tb_data_memory_master;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = 32'd0;
    logic [1:0]  i_req_size = 2'd0;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_wrData = 32'd0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdData;
    logic        o_rsp_error;
    logic [31:0] o_bus_addr;
    logic        o_bus_wrEnable;
    logic [3:0]  o_bus_wrMask;
    logic [31:0] o_bus_wrData;
    logic [31:0] i_bus_rdData = 32'd0;
    logic [1:0]  dbg_state;

    data_memory_master dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wrData(i_req_wrData),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdData(o_rsp_rdData), .o_rsp_error(o_rsp_error),
        .o_bus_addr(o_bus_addr), .o_bus_wrEnable(o_bus_wrEnable), .o_bus_wrMask(o_bus_wrMask),
        .o_bus_wrData(o_bus_wrData), .i_bus_rdData(i_bus_rdData), .dbg_state(dbg_state)
    );

    always #5 i_clock = ~i_clock;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        wr_en;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_lanes;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        rsp_valid;
        logic [31:0] rd;
        logic        err;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- memories ----------------
    logic [31:0] slave_mem [logic [29:0]];
    logic [7:0]  ref_mem   [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (slave_mem.exists(a[31:2])) return slave_mem[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(a[31:2]);
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        slave_mem[a[31:2]] = v;
        for (int i = 0; i < 4; i++) ref_mem[{a[31:2], 2'b00} + 32'(i)] = v[8*i +: 8];
    endtask

    // Bus slave: combinational read, writes sampled mid-cycle and committed at the edge.
    logic        pend_en = 1'b0;
    logic [31:0] pend_addr, pend_data;
    logic [3:0]  pend_mask;

    always @(o_bus_addr, negedge i_clock) i_bus_rdData = slave_rd(o_bus_addr);

    always @(negedge i_clock) begin
        pend_en   = o_bus_wrEnable;
        pend_addr = o_bus_addr;
        pend_mask = o_bus_wrMask;
        pend_data = o_bus_wrData;
    end

    always @(posedge i_clock) begin
        logic [31:0] w;
        if (pend_en && i_reset) begin
            w = slave_rd(pend_addr);
            for (int i = 0; i < 4; i++) if (pend_mask[i]) w[8*i +: 8] = pend_data[8*i +: 8];
            slave_mem[pend_addr[31:2]] = w;
        end
    end

    // ---------------- behavioural model ----------------
    // Works byte by byte: which bytes the access touches and which bus word each lands in.
    task automatic model_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                             input bit uns, input logic [31:0] wd, input bit commit,
                             output cyc_t c1, output cyc_t c2, output bit split, output cyc_t cr);
        int off, nb, lane;
        bit illegal, mis, err;
        logic [3:0]  m1, m2;
        logic [31:0] d1, d2, val;
        off = int'(a[1:0]);
        illegal = (sz == 2'd3);
        nb = illegal ? 0 : (1 << sz);
        mis = (off + nb > 4);
`ifdef DATA_MEMORY_MASTER_MISALIGNED_EN
        split = mis;
        err   = illegal;
`else
        split = 1'b0;
        err   = illegal || mis;
`endif
        m1 = '0; m2 = '0; d1 = '0; d2 = '0;
        for (int i = 0; i < 4; i++) begin
            lane = off + i;
            if (lane < 4) begin
                d1[8*lane +: 8] = wd[8*i +: 8];
                if (i < nb) m1[lane] = 1'b1;
            end else begin
                d2[8*(lane-4) +: 8] = wd[8*i +: 8];
                if (i < nb) m2[lane-4] = 1'b1;
            end
        end
        c1 = '0; c2 = '0; cr = '0;
        c1.chk_addr = 1'b1; c1.addr = {a[31:2], 2'b00};
        c1.wr_en = wr && !err; c1.chk_lanes = c1.wr_en; c1.mask = m1; c1.data = d1;
        c2.chk_addr = 1'b1; c2.addr = {a[31:2], 2'b00} + 32'd4;
        c2.wr_en = wr; c2.chk_lanes = wr; c2.mask = m2; c2.data = d2;
        cr.rsp_valid = 1'b1; cr.chk_lanes = 1'b1; cr.err = err;
        val = '0;
        if (!wr && !err) begin
            for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_byte(a + 32'(i));
            if (nb < 4 && !uns && val[8*nb-1])
                for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end
        cr.rd = val;
        if (commit && wr && !err)
            for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    // ---------------- compare process ----------------
    always @(negedge i_clock) begin
        cyc_t c;
        if (!i_reset) begin
            chk("rst_ready", o_req_ready, 1);
            chk("rst_rsp_valid", o_rsp_valid, 0);
            chk("rst_rd", o_rsp_rdData, 0);
            chk("rst_err", o_rsp_error, 0);
            chk("rst_addr", o_bus_addr, 0);
            chk("rst_wr_en", o_bus_wrEnable, 0);
            chk("rst_mask", o_bus_wrMask, 0);
            chk("rst_data", o_bus_wrData, 0);
        end else if (exp_q.size() == 0) begin
            chk("idle_ready", o_req_ready, 1);
            chk("idle_rsp_valid", o_rsp_valid, 0);
            chk("idle_wr_en", o_bus_wrEnable, 0);
            chk("idle_mask", o_bus_wrMask, 0);
            chk("idle_data", o_bus_wrData, 0);
        end else begin
            c = exp_q.pop_front();
            chk("busy_ready", o_req_ready, 0);
            chk("wr_en", o_bus_wrEnable, c.wr_en);
            chk("rsp_valid", o_rsp_valid, c.rsp_valid);
            if (c.chk_addr) chk("bus_addr", o_bus_addr, c.addr);
            if (c.chk_lanes) begin
                chk("wr_mask", o_bus_wrMask, c.mask);
                chk("wr_data", o_bus_wrData, c.data);
            end
            if (c.rsp_valid) begin
                chk("rsp_rd", o_rsp_rdData, c.rd);
                chk("rsp_err", o_rsp_error, c.err);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input bit uns, input logic [31:0] wd, input bit immediate);
        cyc_t c1, c2, cr;
        bit sp;
        int budget;
        if (!immediate) begin
            budget = 0;
            do begin
                @(negedge i_clock);
                budget++;
            end while (!o_req_ready && budget < 20);
            chk("ready_wait", o_req_ready, 1);
            if (!o_req_ready) return;
        end
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = a;
        i_req_size = sz; i_req_unsigned = uns; i_req_wrData = wd;
        @(posedge i_clock);
        model_req(wr, a, sz, uns, wd, 1'b1, c1, c2, sp, cr);
        exp_q.push_back(c1);
        if (sp) exp_q.push_back(c2);
        exp_q.push_back(cr);
        #1;
        i_req_valid = 1'b1;
        i_req_write = 1'($urandom_range(0, 1)); i_req_addr = $urandom;
        i_req_size = 2'($urandom_range(0, 3)); i_req_wrData = $urandom;
        @(negedge i_clock);
        i_req_valid = 1'b0;
    endtask

    task automatic pin_model();
        cyc_t c1, c2, cr;
        bit sp;
        model_req(1, 32'h102, 2'd0, 0, 32'h0000_00A5, 0, c1, c2, sp, cr);
        chk("pin_b_addr", c1.addr, 32'h100);
        chk("pin_b_mask", c1.mask, 4'b0100);
        chk("pin_b_data", c1.data, 32'h00A5_0000);
        chk("pin_b_split", sp, 0);
        model_req(0, 32'h202, 2'd1, 0, 0, 0, c1, c2, sp, cr);
        chk("pin_lh", cr.rd, 32'hFFFF_80FF);
        model_req(0, 32'h203, 2'd0, 1, 0, 0, c1, c2, sp, cr);
        chk("pin_lbu", cr.rd, 32'h0000_0080);
        model_req(1, 32'h301, 2'd2, 0, 32'h1122_3344, 0, c1, c2, sp, cr);
`ifdef DATA_MEMORY_MASTER_MISALIGNED_EN
        chk("pin_sw_m1", c1.mask, 4'b1110);
        chk("pin_sw_d1", c1.data, 32'h2233_4400);
        chk("pin_sw_a2", c2.addr, 32'h304);
        chk("pin_sw_m2", c2.mask, 4'b0001);
        chk("pin_sw_d2", c2.data, 32'h0000_0011);
        chk("pin_sw_split", sp, 1);
        chk("pin_sw_err", cr.err, 0);
`else
        chk("pin_sw_wr_en", c1.wr_en, 0);
        chk("pin_sw_split", sp, 0);
        chk("pin_sw_err", cr.err, 1);
`endif
        model_req(0, 32'hFFFF_FFFE, 2'd2, 0, 0, 0, c1, c2, sp, cr);
`ifdef DATA_MEMORY_MASTER_MISALIGNED_EN
        chk("pin_wrap_a2", c2.addr, 32'h0);
        chk("pin_wrap_rd", cr.rd, 32'h3344_AABB);
`else
        chk("pin_wrap_err", cr.err, 1);
        chk("pin_wrap_rd", cr.rd, 32'h0);
`endif
    endtask

    task automatic reset_mid_access();
        issue(1, 32'h0000_8001, 2'd2, 0, 32'hDEAD_BEEF, 0);
        @(posedge i_clock);
        #2;
        i_reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_now_ready", o_req_ready, 1);
        chk("rst_now_wr_en", o_bus_wrEnable, 0);
        chk("rst_now_addr", o_bus_addr, 0);
        chk("rst_now_mask", o_bus_wrMask, 0);
        chk("rst_now_data", o_bus_wrData, 0);
        chk("rst_now_rsp", o_rsp_valid, 0);
        @(negedge i_clock);
        @(negedge i_clock);
        #2;
        i_reset = 1'b1;
        issue(0, 32'h200, 2'd2, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int r, budget;
        preload(32'h200, 32'h80FF_7F01);
        preload(32'hFFFF_FFFC, 32'hAABB_CCDD);
        preload(32'h0, 32'h1122_3344);
        repeat (3) @(negedge i_clock);
        pin_model();
        #2;
        i_reset = 1'b1;
        issue(1, 32'h102, 2'd0, 0, 32'h0000_00A5, 1);
        issue(0, 32'h202, 2'd1, 0, 0, 0);
        issue(0, 32'h203, 2'd0, 1, 0, 0);
        issue(1, 32'h301, 2'd2, 0, 32'h1122_3344, 0);
        issue(0, 32'h300, 2'd2, 0, 0, 0);
        issue(0, 32'h304, 2'd2, 0, 0, 0);
        issue(0, 32'hFFFF_FFFE, 2'd2, 0, 0, 0);
        issue(1, 32'h40, 2'd3, 0, 32'h1234_5678, 0);
        issue(0, 32'h40, 2'd3, 1, 0, 0);
        issue(1, 32'h7, 2'd1, 0, 32'hCAFE_BABE, 0);
        issue(0, 32'h7, 2'd1, 0, 0, 0);
        reset_mid_access();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 1023));
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            repeat ($urandom_range(0, 2)) @(negedge i_clock);
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 0);
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge i_clock);
            budget++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge i_clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_master.md
DATA_MEMORY_MASTER -- requirements
Module: data_memory_master

Interface
REQ-001 No parameters SHALL exist; address and data widths SHALL be fixed at 32 bits.
REQ-002 i_clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_req_valid  in  1  CPU request valid.
REQ-005 o_req_ready  out  1  request accepted when valid and ready are both 1 at a rising edge.
REQ-006 i_req_write  in  1  1 = store, 0 = load.
REQ-007 i_req_addr  in  32  byte address.
REQ-008 i_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-009 i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 i_req_wrData  in  32  store data, right-justified.
REQ-011 o_rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
REQ-012 o_rsp_rdData  out  32  extended load data; 0 for stores and errors.
REQ-013 o_rsp_error  out  1  misaligned or illegal-size request.
REQ-014 o_bus_addr, o_bus_wrEnable, o_bus_wrMask, o_bus_wrData  out  32/1/4/32  master side of DataMemoryBus.
REQ-015 i_bus_rdData  in  32  combinational read data from the slave at o_bus_addr.

Function
REQ-016 States SHALL be IDLE, ACC1, ACC2, RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance the request SHALL be registered and the state SHALL move to ACC1.
REQ-018 o_bus_addr SHALL always be word-aligned: {addr[31:2], 2'b00} in ACC1 and that value + 4 (modulo 2^32) in ACC2, so 0xFFFFFFFC wraps to 0x00000000.
REQ-019 o_bus_wrEnable SHALL be 1 only in ACC1 or ACC2 of a non-error store; outside those states o_bus_wrMask and o_bus_wrData SHALL be 0.
REQ-020 Store lanes for offset off = addr[1:0]:
- o_bus_wrMask = (byte 0001, half 0011, word 1111) << off, truncated to 4 bits in ACC1.
- The bits shifted out of the mask SHALL form the ACC2 mask.
- Data SHALL be shifted left by 8*off in ACC1; the overflow bytes SHALL go to ACC2.
REQ-021 A load SHALL capture i_bus_rdData at the end of each ACC cycle.
- Bytes SHALL be assembled from the ACC1 word shifted right by 8*off, plus the ACC2 low bytes placed above them.
- The result SHALL then be sign- or zero-extended per i_req_size and i_req_unsigned.
REQ-022 A request is misaligned when it is a half with off = 3, or a word with off != 0.
- An aligned request SHALL go ACC1 -> RESP.
- A misaligned request SHALL be handled per REQ-029/030.
REQ-023 In RESP, o_rsp_valid SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
- Latency for accept at edge N: aligned response in cycle N+2; split response in cycle N+3.
REQ-024 i_req_size = 3 SHALL go ACC1 -> RESP with o_rsp_error = 1, no bus write and o_rsp_rdData = 0.
REQ-025 Request inputs SHALL be ignored outside IDLE; back-to-back requests SHALL be accepted in the cycle after RESP.

Reset
REQ-026 While i_reset = 0, the state SHALL be IDLE and every output SHALL be 0 except o_req_ready, which SHALL be 1.
REQ-027 Reset asserted in ACC2 SHALL abort the access; the ACC1 half of a split store MAY already have been written, and no response SHALL be issued.
REQ-028 After i_reset deasserts, the first request SHALL be acceptable at the first rising edge.

Configuration
REQ-029 With DATA_MEMORY_MASTER_MISALIGNED_EN defined, a misaligned request SHALL go ACC1 -> ACC2 -> RESP as a split access with o_rsp_error = 0.
REQ-030 Without the macro, a misaligned request SHALL go ACC1 -> RESP with o_bus_wrEnable = 0, o_rsp_error = 1 and o_rsp_rdData = 0; ACC2 SHALL never be entered.

Verification
REQ-031 Store byte 0xA5 at 0x102 -> ACC1: addr 0x100, mask 0100, wrData 0x00A50000; rsp_valid in cycle N+2.
REQ-032 Memory word 0x80FF7F01 at 0x200: load half signed at 0x202 -> 0xFFFF80FF; load byte unsigned at 0x203 -> 0x00000080.
REQ-033 Macro defined: store word 0x11223344 at 0x301:
- ACC1: addr 0x300, mask 1110, data 0x22334400.
- ACC2: addr 0x304, mask 0001, data 0x00000011.
- Response in cycle N+3 with error 0.
REQ-034 Macro undefined: the same store -> no wrEnable pulse, rsp_valid with error 1 in cycle N+2.
REQ-035 Macro defined: load word at 0xFFFFFFFE -> ACC2 addr 0x00000000; result = {mem[0x0][15:0], mem[0xFFFFFFFC][31:16]}.
REQ-036 i_reset pulsed low during ACC2 of a split store -> outputs 0 immediately, no rsp_valid, o_req_ready = 1.
